if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//   Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core; feeds ID, whose outputs enter ID_EX.
//   Owns the PC and drives a req/ack instruction-memory port that tolerates wait states (cache miss).
//   Honours the load-use stall from the hazard unit and the taken-branch/jump flush from ID.
//   Presents {inst, pc+4, valid} to ID; a bubble is inst=0 (NOP), valid=0.
// PARAMETERS
//   RESET_PC   32'h0000_0000   first fetch address after reset
// PORTS
//   clk_i            in   1   clock, rising edge
//   rst_i            in   1   reset, synchronous, active-high
//   stall_i          in   1   hazard unit: hold PC and IF/ID contents
//   flush_i          in   1   ID: branch/jump taken; squash IF/ID, redirect PC
//   target_i         in   32  redirect address, sampled when flush_i=1
//   imem_req_o       out  1   instruction read request
//   imem_addr_o      out  32  read address, word aligned
//   imem_ack_i       in   1   read done this cycle; imem_data_i valid with it
//   imem_data_i      in   32  instruction word
//   inst_o           out  32  IF/ID instruction (0 when bubble)
//   pc_o             out  32  IF/ID pc+4 of inst_o
//   valid_o          out  1   IF/ID holds a real instruction
//   fetch_busy_o     out  1   1 while a request is outstanding without ack
// BEHAVIOUR
// - Reset (rst_i=1 at edge): fetch_pc=RESET_PC, state=FETCH, inst_o=0, pc_o=0, valid_o=0, hold buffer=0.
//   imem_req_o=0 while rst_i=1; req first rises in the cycle after reset is released. Reset beats all other inputs.
// - State FETCH: req=1, addr=fetch_pc, held stable until ack.
//   - ack, no stall, no flush: IF/ID <= {imem_data_i, fetch_pc+4, 1}; fetch_pc += 4. Latency is zero-wait =
//     one instruction per cycle.
//   - ack & stall: IF/ID holds; data goes to hold buffer; next state HOLD.
//   - no ack, no stall: IF/ID <= bubble. no ack & stall: IF/ID holds.
// - State HOLD: req=0. While stall_i: everything holds. stall_i=0: IF/ID <= {buffer, fetch_pc+4, 1};
//   fetch_pc += 4; next state FETCH.
// - Flush (priority over stall): IF/ID <= bubble on every flush edge.
//   - In FETCH with ack, or in HOLD: data/buffer dropped; fetch_pc <= target_i; next state FETCH.
//   - In FETCH without ack: the outstanding request cannot be withdrawn. Save target_i; next state DRAIN.
// - State DRAIN: req=1, addr = old fetch_pc unchanged. A further flush overwrites the saved target.
//   On ack: data discarded, fetch_pc <= saved target, next state FETCH. IF/ID = bubble (or held if stall_i)
//   throughout DRAIN.
// - fetch_busy_o = req & ~ack (combinational).
// - PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0. target_i[1:0] are forced to 0.
// - pc_o: computed as the fetch_pc+4 of the word actually registered, never of a discarded word.
// TESTING
// 1. Reset, ack tied 1, mem[i]=i: addr 0,4,8 on consecutive cycles. inst_o = 0,1,2 with pc_o = 4,8,12,
//    each one edge after its ack.
// 2. ack delayed 3 cycles for addr 0x8: addr/req stable for 4 cycles, fetch_busy_o=1 for 3,
//    valid_o=0 for 3 cycles, then inst at 0x8.
// 3. stall_i=1 for 2 cycles coincident with ack of 0xC: req drops, inst_o/pc_o frozen.
//    On release inst(0xC), pc_o=0x10, then next addr 0x10.
// 4. flush_i with target_i=0x100 in a cycle with ack: ack data discarded, valid_o=0 next cycle,
//    next imem_addr_o=0x100.
// 5. flush target 0x200 while 0x40 is in wait: addr stays 0x40 until ack, data discarded,
//    then addr 0x200. Second flush (0x300) during DRAIN -> 0x300 wins.
// 6. rst_i asserted mid-DRAIN and mid-HOLD: next cycle all outputs zero, req=0;
//    after release first addr=RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   Instruction fetch and IF/ID pipeline register for the 5-stage MIPS core.
//   The stage owns the fetch PC and drives a req/ack instruction-memory port
//   that may insert wait states. It honours the hazard-unit stall and the
//   branch/jump flush from ID. ID receives {inst, pc+4, valid}; a bubble is
//   presented as inst=0 with valid=0.
//
// Ports
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   stall_i               hold the PC and the IF/ID contents
//   flush_i, target_i     squash IF/ID and redirect the PC to target_i
//   imem_req_o/addr_o     read request and word-aligned read address
//   imem_ack_i/data_i     read completion and instruction word (same cycle)
//   inst_o, pc_o, valid_o IF/ID register: instruction, its pc+4, real-inst flag
//   fetch_busy_o          a request is outstanding and not acked this cycle
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    output logic        fetch_busy_o
);

    // FETCH: request live. HOLD: word parked in the buffer while stalled.
    // DRAIN: a flush arrived while the request was still outstanding; wait
    //        out the ack, throw the word away, then jump to the saved target.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] target_q, target_d;

    logic        req;
    logic        ack;
    logic [31:0] tgt;
    logic [31:0] pc_plus4;

    assign req      = ~rst_i & (state_q != S_HOLD);
    assign ack      = req & imem_ack_i;     // an ack without a live request is ignored
    assign tgt      = {target_i[31:2], 2'b00};
    assign pc_plus4 = fetch_pc_q + 32'd4;   // 32-bit wrap is intended

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        hold_d     = hold_q;
        target_d   = target_q;

        // Flush always squashes IF/ID, even when stalled.
        if (flush_i) begin
            inst_d  = 32'd0;
            pc_d    = 32'd0;
            valid_d = 1'b0;
        end

        case (state_q)
            S_FETCH: begin
                if (flush_i) begin
                    if (ack) begin
                        fetch_pc_d = tgt;
                    end else begin
                        // Request cannot be withdrawn; remember where to go.
                        target_d = tgt;
                        state_d  = S_DRAIN;
                    end
                end else if (ack) begin
                    if (stall_i) begin
                        hold_d  = imem_data_i;
                        state_d = S_HOLD;
                    end else begin
                        inst_d     = imem_data_i;
                        pc_d       = pc_plus4;
                        valid_d    = 1'b1;
                        fetch_pc_d = pc_plus4;
                    end
                end else if (!stall_i) begin
                    inst_d  = 32'd0;
                    pc_d    = 32'd0;
                    valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (flush_i) begin
                    fetch_pc_d = tgt;
                    state_d    = S_FETCH;
                end else if (!stall_i) begin
                    inst_d     = hold_q;
                    pc_d       = pc_plus4;
                    valid_d    = 1'b1;
                    fetch_pc_d = pc_plus4;
                    state_d    = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (flush_i) begin
                    // Newest flush wins, whether or not the ack lands now.
                    if (ack) begin
                        fetch_pc_d = tgt;
                        state_d    = S_FETCH;
                    end else begin
                        target_d = tgt;
                    end
                end else begin
                    if (ack) begin
                        fetch_pc_d = target_q;
                        state_d    = S_FETCH;
                    end
                    if (!stall_i) begin
                        inst_d  = 32'd0;
                        pc_d    = 32'd0;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= {RESET_PC[31:2], 2'b00};
            inst_q     <= 32'd0;
            pc_q       <= 32'd0;
            valid_q    <= 1'b0;
            hold_q     <= 32'd0;
            target_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            hold_q     <= hold_d;
            target_q   <= target_d;
        end
    end

    assign imem_req_o   = req;
    assign imem_addr_o  = fetch_pc_q;
    assign fetch_busy_o = req & ~imem_ack_i;
    assign inst_o       = inst_q;
    assign pc_o         = pc_q;
    assign valid_o      = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios followed by random traffic,
// all checked against a flag-based behavioural model of the fetch stage.
module tb_if_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] target_i = 32'd0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = 32'd0;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        fetch_busy_o;

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .target_i    (target_i),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_ack_i  (imem_ack_i),
        .imem_data_i (imem_data_i),
        .inst_o      (inst_o),
        .pc_o        (pc_o),
        .valid_o     (valid_o),
        .fetch_busy_o(fetch_busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Model: next address to fetch, an optional parked word, an optional
    // pending redirect, and what ID should currently be seeing.
    logic [31:0] m_pc;
    bit          m_buf_v;
    logic [31:0] m_buf;
    bit          m_redir_v;
    logic [31:0] m_redir;
    logic [31:0] m_inst;
    logic [31:0] m_pcq;
    bit          m_valid;
    bit          m_pc_chk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a >> 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic bubble();
        m_inst = 32'd0;
        m_valid = 1'b0;
    endtask

    task automatic deliver(input logic [31:0] w);
        m_inst  = w;
        m_pcq   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
    endtask

    task automatic step(input bit r, input bit st, input bit fl,
                        input logic [31:0] tg, input bit ack);
        bit          m_req;
        bit          a;
        logic [31:0] t;
        logic [31:0] w;
        m_req = !r && !m_buf_v;
        a = ack && m_req;
        w = memw(imem_addr_o);
        rst_i       = r;
        stall_i     = st;
        flush_i     = fl;
        target_i    = tg;
        imem_ack_i  = a;
        imem_data_i = w;
        #1;
        chk("req", {31'd0, imem_req_o}, {31'd0, m_req});
        chk("busy", {31'd0, fetch_busy_o}, {31'd0, m_req && !a});
        if (m_req) chk("addr", imem_addr_o, m_pc);

        t = {tg[31:2], 2'b00};
        m_pc_chk = 1'b0;
        if (r) begin
            m_pc = 32'd0; m_buf_v = 0; m_buf = 0; m_redir_v = 0; m_redir = 0;
            m_inst = 0; m_pcq = 0; m_valid = 0; m_pc_chk = 1'b1;
        end else if (fl) begin
            bubble();
            if (!m_req) begin
                m_buf_v = 0; m_pc = t;
            end else if (a) begin
                m_redir_v = 0; m_pc = t;
            end else begin
                m_redir_v = 1; m_redir = t;
            end
        end else if (m_buf_v) begin
            if (!st) begin
                deliver(m_buf);
                m_buf_v = 0;
            end
        end else if (a) begin
            if (m_redir_v) begin
                m_pc = m_redir; m_redir_v = 0;
                if (!st) bubble();
            end else if (st) begin
                m_buf_v = 1; m_buf = memw(m_pc);
            end else begin
                deliver(memw(m_pc));
            end
        end else if (!st) begin
            bubble();
        end
        if (m_valid) m_pc_chk = 1'b1;

        @(posedge clk_i);
        #1;
        chk("inst", inst_o, m_inst);
        chk("valid", {31'd0, valid_o}, {31'd0, m_valid});
        if (m_pc_chk) chk("pc", pc_o, m_pcq);
    endtask

    initial begin
        m_pc = 0; m_buf_v = 0; m_buf = 0; m_redir_v = 0; m_redir = 0;
        m_inst = 0; m_pcq = 0; m_valid = 0; m_pc_chk = 0;
        @(posedge clk_i);
        #1;
        // Reset
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        // Zero-wait streaming: 0,4,8 -> inst 0,1,2, pc 4,8,12
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // Three wait states on 0xC
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        // Stall coinciding with ack of 0x10, held two cycles, then release
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // Flush with ack to 0x100 (low bits of target ignored)
        step(0, 0, 1, 32'h0000_0103, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // Flush during a wait state, second flush during drain wins
        step(0, 0, 1, 32'h0000_0200, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h0000_0300, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // PC wrap at the top of the address space
        step(0, 0, 1, 32'hFFFF_FFF8, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // Reset in the middle of a drain
        step(0, 0, 1, 32'h0000_0400, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        // Reset while a word is parked
        step(0, 1, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // Flush out of the parked state
        step(0, 1, 0, 0, 1);
        step(0, 1, 1, 32'h0000_0500, 0);
        step(0, 0, 0, 0, 1);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 12),
                 $urandom(),
                 ($urandom_range(0, 99) < 60));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
